conv_controller: RTL
====================

// Module: conv_controller
// PURPOSE
//  Sequencer FSM for the CNN convolution DataPath. It issues every DataPath control strobe, counter and address.
//  Per run, in order:
//    1. loads the filter of each of the N PEs from memory,
//    2. fills the main buffer one input row-slice at a time,
//    3. slides the shift-buffer window,
//    4. runs the PE MACs and writes each output-feature-map (OFM) word.
//  One start pulse produces one complete OFM pass; ends with a one-cycle done pulse.
// PARAMETERS
//  N            4    number of PEs (width of wEnFilter)
//  FILT_LEN     9    filter words loaded per PE
//  FILT_BASE    0    memory word address of PE0 filter word 0; PE p at FILT_BASE+p*FILT_LEN
//  IFM_BASE     64   memory word address of input row 0
//  ROW_STRIDE   16   memory words between consecutive input row-slices
//  BUF_LEN      48   main-buffer words written per row-slice (<=64)
//  WIN_LEN      9    window shifts for the first window of a row
//  STRIDE       1    window shifts between neighbouring windows in a row
//  MAC_LEN      9    MAC cycles per output
//  OUT_PER_ROW  4    outputs produced per row-slice
//  OFM_COUNT    16   total outputs per run (<=256, multiple of OUT_PER_ROW)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous, active-low reset
//  start          in   1   run request, sampled only in IDLE
//  busy           out  1   high in every state except IDLE
//  done           out  1   one-cycle pulse in DONE
//  wEnBuff        out  1   main-buffer write enable
//  w_r_EnMem      out  1   memory write/read select; held 0 (read) always
//  writeEnwindow  out  1   shift-buffer shift enable
//  readEnmac      out  1   shift-buffer read / PE MAC enable
//  addEn          out  1   PE accumulate enable
//  winRst         out  1   PE accumulator clear
//  wrofm          out  1   PE OFM write strobe
//  filterCount    out  6   filter word index within PE
//  macCount       out  6   MAC step index
//  memAddress     out  10  memory word address
//  buffAddress    out  6   main-buffer write address
//  ofmaddr        out  8   OFM word address = current output index
//  wEnFilter      out  N   one-hot filter-load enable, bit p = PE p
// BEHAVIOUR
//  Reset and output defaults
//  - rst low: state=IDLE immediately; all outputs, counters, row and ofm index cleared to 0.
//  - Reset mid-run aborts with no done pulse.
//  - All outputs are registered-state decodes (Moore). Any strobe not named for a state is 0.
//  - Counters hold their last value outside the states that drive them.
//  - Memory read data is combinational, so each strobe's data is valid in the same cycle as its address.
//  States (each cycle below is one clk)
//  - IDLE: start=1 -> LOAD_FILT (pe=0,k=0); start=0 -> stay. start outside IDLE is ignored.
//  - LOAD_FILT: wEnFilter=1<<pe, filterCount=k, memAddress=FILT_BASE+pe*FILT_LEN+k.
//    k increments; at k=FILT_LEN-1, k=0 and pe++. After pe=N-1,k=FILT_LEN-1 -> LOAD_BUFF (row=0).
//  - LOAD_BUFF: wEnBuff=1, buffAddress=i, memAddress=IFM_BASE+row*ROW_STRIDE+i, i=0..BUF_LEN-1.
//    Then -> FILL_WIN with shift count WIN_LEN.
//  - FILL_WIN: writeEnwindow=1 for the loaded shift count (WIN_LEN first window of a row, else STRIDE) -> CLR.
//  - CLR: winRst=1 for one cycle -> MAC.
//  - MAC: readEnmac=1, addEn=1, macCount=0..MAC_LEN-1 -> WRITE.
//  - WRITE: wrofm=1, ofmaddr=ofm for one cycle. Then:
//      ofm=OFM_COUNT-1                      -> DONE
//      else (ofm+1)%OUT_PER_ROW==0          -> LOAD_BUFF, row++
//      else                                 -> FILL_WIN with STRIDE
//    ofm increments on leaving WRITE.
//  - DONE: done=1, busy=1 for one cycle -> IDLE. ofm, row, pe cleared on entry to IDLE.
//  Width rules
//  - Address sums are computed at full width and truncated modulo 2^10 on memAddress.
//  - macCount and filterCount are 6-bit. Parameters must satisfy FILT_LEN<=64, MAC_LEN<=64, N>=1.
//  - Latency = N*FILT_LEN + rows*(BUF_LEN + WIN_LEN+MAC_LEN+2 + (OUT_PER_ROW-1)*(STRIDE+MAC_LEN+2)) + 1 cycles.
//    rows = OFM_COUNT/OUT_PER_ROW; count from the first LOAD_FILT cycle to DONE inclusive.
// TESTING (default parameters)
//  - Reset: drive rst=0 mid-MAC of output 5 -> next cycle all outputs 0, busy=0.
//    Then start -> filter load restarts at memAddress 0.
//  - Filter load: start pulse -> 36 cycles of LOAD_FILT.
//    wEnFilter=0001 for addr 0..8, then 0010 for 9..17, ..., 1000 for addr 27..35. filterCount cycles 0..8.
//  - Row loads: wEnBuff high 48 cycles at memAddress 64..111 (row 0).
//    Row 1 covers 80..127; buffAddress 0..47 each time.
//  - Windows: row 0 output 0 gets 9 writeEnwindow cycles; outputs 1-3 get 1 cycle each.
//    winRst one cycle before each 9-cycle MAC burst (macCount 0..8).
//  - Full run: done pulses in cycle 453 after start is sampled.
//    wrofm pulses exactly 16 times with ofmaddr 0..15 in order; w_r_EnMem never 1.
//  - start held high through the run and asserted during busy -> no restart.
//    A second run begins only from IDLE, one cycle after done.

Source files
------------

// File: rtl/conv_controller.sv
// conv_controller: sequencer FSM for the CNN convolution datapath.
// One start pulse walks through the filter load, then per input row-slice the
// main-buffer fill followed by window shift / clear / MAC / OFM write for every
// output of that row, and finishes with a one-cycle done pulse.
// All outputs are registered and are pure decodes of the registered state, so
// every strobe and its address appear in the same cycle.
module conv_controller #(
  parameter int N           = 4,
  parameter int FILT_LEN    = 9,
  parameter int FILT_BASE   = 0,
  parameter int IFM_BASE    = 64,
  parameter int ROW_STRIDE  = 16,
  parameter int BUF_LEN     = 48,
  parameter int WIN_LEN     = 9,
  parameter int STRIDE      = 1,
  parameter int MAC_LEN     = 9,
  parameter int OUT_PER_ROW = 4,
  parameter int OFM_COUNT   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         wEnBuff,
  output logic         w_r_EnMem,
  output logic         writeEnwindow,
  output logic         readEnmac,
  output logic         addEn,
  output logic         winRst,
  output logic         wrofm,
  output logic [5:0]   filterCount,
  output logic [5:0]   macCount,
  output logic [9:0]   memAddress,
  output logic [5:0]   buffAddress,
  output logic [7:0]   ofmaddr,
  output logic [N-1:0] wEnFilter
);

  localparam int PE_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_FILT,
    S_LOAD_BUFF,
    S_FILL_WIN,
    S_CLR,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  // Registered state and loop indices
  state_t           r_state;
  logic [PE_W-1:0]  r_pe;
  logic [5:0]       r_k;
  logic [5:0]       r_i;
  logic [7:0]       r_row;
  logic [7:0]       r_ofm;
  logic [7:0]       r_shift;
  logic [5:0]       r_mac;

  // Registered outputs
  logic             r_busy;
  logic             r_done;
  logic             r_wEnBuff;
  logic             r_writeEnwindow;
  logic             r_mac_en;
  logic             r_winRst;
  logic             r_wrofm;
  logic [5:0]       r_filterCount;
  logic [5:0]       r_macCount;
  logic [9:0]       r_memAddress;
  logic [5:0]       r_buffAddress;
  logic [7:0]       r_ofmaddr;
  logic [N-1:0]     r_wEnFilter;

  // Next-cycle values
  state_t           w_state;
  logic [PE_W-1:0]  w_pe;
  logic [5:0]       w_k;
  logic [5:0]       w_i;
  logic [7:0]       w_row;
  logic [7:0]       w_ofm;
  logic [7:0]       w_shift;
  logic [5:0]       w_mac;
  logic [7:0]       w_ofm_inc;
  logic [9:0]       w_filt_addr;
  logic [9:0]       w_ifm_addr;

  assign w_ofm_inc = r_ofm + 8'd1;

  // Addresses wrap modulo 2^10; doing the sum in 10 bits gives the same result.
  assign w_filt_addr = 10'(FILT_BASE) + 10'(w_pe) * 10'(FILT_LEN) + 10'(w_k);
  assign w_ifm_addr  = 10'(IFM_BASE) + 10'(w_row) * 10'(ROW_STRIDE) + 10'(w_i);

  // Next-state and next-index selection for the run sequence
  always_comb begin
    w_state = r_state;
    w_pe    = r_pe;
    w_k     = r_k;
    w_i     = r_i;
    w_row   = r_row;
    w_ofm   = r_ofm;
    w_shift = r_shift;
    w_mac   = r_mac;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_LOAD_FILT;
          w_pe    = '0;
          w_k     = '0;
        end
      end
      S_LOAD_FILT: begin
        if (r_k == 6'(FILT_LEN - 1)) begin
          w_k = '0;
          if (r_pe == PE_W'(N - 1)) begin
            w_state = S_LOAD_BUFF;
            w_row   = '0;
            w_i     = '0;
          end else begin
            w_pe = r_pe + 1'b1;
          end
        end else begin
          w_k = r_k + 6'd1;
        end
      end
      S_LOAD_BUFF: begin
        if (r_i == 6'(BUF_LEN - 1)) begin
          w_state = S_FILL_WIN;
          w_shift = 8'(WIN_LEN);
        end else begin
          w_i = r_i + 6'd1;
        end
      end
      S_FILL_WIN: begin
        // r_shift holds the shifts still to do, including the current cycle
        if (r_shift <= 8'd1) begin
          w_state = S_CLR;
        end else begin
          w_shift = r_shift - 8'd1;
        end
      end
      S_CLR: begin
        w_state = S_MAC;
        w_mac   = '0;
      end
      S_MAC: begin
        if (r_mac == 6'(MAC_LEN - 1)) begin
          w_state = S_WRITE;
        end else begin
          w_mac = r_mac + 6'd1;
        end
      end
      S_WRITE: begin
        w_ofm = w_ofm_inc;
        if (r_ofm == 8'(OFM_COUNT - 1)) begin
          w_state = S_DONE;
        end else if (({24'd0, w_ofm_inc} % 32'(OUT_PER_ROW)) == 32'd0) begin
          w_state = S_LOAD_BUFF;
          w_row   = r_row + 8'd1;
          w_i     = '0;
        end else begin
          w_state = S_FILL_WIN;
          w_shift = 8'(STRIDE);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_ofm   = '0;
        w_row   = '0;
        w_pe    = '0;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State, indices and output registers; outputs decode the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_pe            <= '0;
      r_k             <= '0;
      r_i             <= '0;
      r_row           <= '0;
      r_ofm           <= '0;
      r_shift         <= '0;
      r_mac           <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_wEnBuff       <= 1'b0;
      r_writeEnwindow <= 1'b0;
      r_mac_en        <= 1'b0;
      r_winRst        <= 1'b0;
      r_wrofm         <= 1'b0;
      r_filterCount   <= '0;
      r_macCount      <= '0;
      r_memAddress    <= '0;
      r_buffAddress   <= '0;
      r_ofmaddr       <= '0;
      r_wEnFilter     <= '0;
    end else begin
      r_state         <= w_state;
      r_pe            <= w_pe;
      r_k             <= w_k;
      r_i             <= w_i;
      r_row           <= w_row;
      r_ofm           <= w_ofm;
      r_shift         <= w_shift;
      r_mac           <= w_mac;
      r_busy          <= (w_state != S_IDLE);
      r_done          <= (w_state == S_DONE);
      r_wEnBuff       <= (w_state == S_LOAD_BUFF);
      r_writeEnwindow <= (w_state == S_FILL_WIN);
      r_mac_en        <= (w_state == S_MAC);
      r_winRst        <= (w_state == S_CLR);
      r_wrofm         <= (w_state == S_WRITE);
      r_wEnFilter     <= (w_state == S_LOAD_FILT) ? (N'(1) << w_pe) : '0;
      if (w_state == S_LOAD_FILT) begin
        r_filterCount <= w_k;
        r_memAddress  <= w_filt_addr;
      end
      if (w_state == S_LOAD_BUFF) begin
        r_buffAddress <= w_i;
        r_memAddress  <= w_ifm_addr;
      end
      if (w_state == S_MAC) begin
        r_macCount <= w_mac;
      end
      if (w_state == S_WRITE) begin
        r_ofmaddr <= w_ofm;
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign wEnBuff       = r_wEnBuff;
  assign w_r_EnMem     = 1'b0;
  assign writeEnwindow = r_writeEnwindow;
  assign readEnmac     = r_mac_en;
  assign addEn         = r_mac_en;
  assign winRst        = r_winRst;
  assign wrofm         = r_wrofm;
  assign filterCount   = r_filterCount;
  assign macCount      = r_macCount;
  assign memAddress    = r_memAddress;
  assign buffAddress   = r_buffAddress;
  assign ofmaddr       = r_ofmaddr;
  assign wEnFilter     = r_wEnFilter;

endmodule
